// File: rtl/spu_pkg.sv
// Shared SPU types for the register-fetch/forward stage.
// Bit 0 is the MSB for both data and address fields.
package spu_pkg;

  localparam int REG_W    = 128;
  localparam int ADDR_W   = 7;
  localparam int NUM_FW   = 7;
  localparam int NUM_REGS = 128;
  localparam int NUM_OPS  = 6;

  typedef logic [0:REG_W-1]  reg_t;
  typedef logic [0:ADDR_W-1] addr_t;
  typedef reg_t  [0:NUM_FW-1] fw_bus_t;
  typedef addr_t [0:NUM_FW-1] fw_addr_t;
  typedef logic  [0:NUM_FW-1] fw_vld_t;

endpackage

// File: rtl/operand_resolve.sv
// One operand's priority mux: youngest forward stage, then WB,
// then the array value.
module operand_resolve
  import spu_pkg::*;
(
  input  addr_t    addr,
  input  fw_bus_t  fw_e,
  input  fw_addr_t fw_addr_e,
  input  fw_vld_t  fw_write_e,
  input  fw_bus_t  fw_o,
  input  fw_addr_t fw_addr_o,
  input  fw_vld_t  fw_write_o,
  input  reg_t     rt_wb_e,
  input  addr_t    rt_addr_wb_e,
  input  logic     reg_write_wb_e,
  input  reg_t     rt_wb_o,
  input  addr_t    rt_addr_wb_o,
  input  logic     reg_write_wb_o,
  input  reg_t     arr_val,
  output reg_t     operand
);

  // Walk from lowest to highest priority so the last hit wins.
  always_comb begin
    operand = arr_val;
    if (reg_write_wb_e && rt_addr_wb_e == addr)
      operand = rt_wb_e;
    if (reg_write_wb_o && rt_addr_wb_o == addr)
      operand = rt_wb_o;
    for (int i = NUM_FW - 1; i >= 0; i--) begin
      if (fw_write_e[i] && fw_addr_e[i] == addr)
        operand = fw_e[i];
      if (fw_write_o[i] && fw_addr_o[i] == addr)
        operand = fw_o[i];
    end
  end

endmodule

// File: rtl/register_fetch_forward.sv
// RF/FWD stage: SPU register file, address latch and
// registered operands for the even and odd pipes.
module register_fetch_forward
  import spu_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     stall,
  input  addr_t    ra_addr_e,
  input  addr_t    rb_addr_e,
  input  addr_t    rc_addr_e,
  input  addr_t    ra_addr_o,
  input  addr_t    rb_addr_o,
  input  addr_t    rc_addr_o,
  input  fw_bus_t  fw_e,
  input  fw_addr_t fw_addr_e,
  input  fw_vld_t  fw_write_e,
  input  fw_bus_t  fw_o,
  input  fw_addr_t fw_addr_o,
  input  fw_vld_t  fw_write_o,
  input  reg_t     rt_wb_e,
  input  addr_t    rt_addr_wb_e,
  input  logic     reg_write_wb_e,
  input  reg_t     rt_wb_o,
  input  addr_t    rt_addr_wb_o,
  input  logic     reg_write_wb_o,
  output reg_t     ra_e,
  output reg_t     rb_e,
  output reg_t     rc_e,
  output reg_t     ra_o,
  output reg_t     rb_o,
  output reg_t     rc_o
);

  reg_t  arr [NUM_REGS];
  addr_t in_addr  [NUM_OPS];
  addr_t lat_addr [NUM_OPS];
  addr_t res_addr [NUM_OPS];
  reg_t  res_val  [NUM_OPS];
  reg_t  oper_q   [NUM_OPS];

  assign in_addr[0] = ra_addr_e;
  assign in_addr[1] = rb_addr_e;
  assign in_addr[2] = rc_addr_e;
  assign in_addr[3] = ra_addr_o;
  assign in_addr[4] = rb_addr_o;
  assign in_addr[5] = rc_addr_o;

  // Odd write lands last so it wins on an address collision.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NUM_REGS; r++)
        arr[r] <= '0;
    end else begin
      if (reg_write_wb_e)
        arr[rt_addr_wb_e] <= rt_wb_e;
      if (reg_write_wb_o)
        arr[rt_addr_wb_o] <= rt_wb_o;
    end
  end

  for (genvar k = 0; k < NUM_OPS; k++) begin : g_op
    assign res_addr[k] = stall ? lat_addr[k] : in_addr[k];

    operand_resolve u_res (
      .addr           (res_addr[k]),
      .fw_e           (fw_e),
      .fw_addr_e      (fw_addr_e),
      .fw_write_e     (fw_write_e),
      .fw_o           (fw_o),
      .fw_addr_o      (fw_addr_o),
      .fw_write_o     (fw_write_o),
      .rt_wb_e        (rt_wb_e),
      .rt_addr_wb_e   (rt_addr_wb_e),
      .reg_write_wb_e (reg_write_wb_e),
      .rt_wb_o        (rt_wb_o),
      .rt_addr_wb_o   (rt_addr_wb_o),
      .reg_write_wb_o (reg_write_wb_o),
      .arr_val        (arr[res_addr[k]]),
      .operand        (res_val[k])
    );

    // Operands refresh even while stalled to catch late results.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        lat_addr[k] <= '0;
        oper_q[k]   <= '0;
      end else begin
        if (!stall)
          lat_addr[k] <= in_addr[k];
        oper_q[k] <= res_val[k];
      end
    end
  end

  assign ra_e = oper_q[0];
  assign rb_e = oper_q[1];
  assign rc_e = oper_q[2];
  assign ra_o = oper_q[3];
  assign rb_o = oper_q[4];
  assign rc_o = oper_q[5];

endmodule

// File: doc/register_fetch_forward.md
Name: register_fetch_forward

Overview:
- Register-fetch/forward (RF/FWD) stage that feeds operands to the even and odd execution pipes.
- Holds the 128 x 128-bit SPU register file, written from both pipes' WB outputs.
- Resolves six source operands per cycle: ra/rb/rc for each pipe slot.
- Priority order for each operand: youngest matching forwarding stage, then WB, then array.
- Operands are registered, so they are stable for the pipes' first execute cycle.

Parameters:
- NUM_REGS, 128, register count; address width is 7.
- REG_W, 128, register width; bit 0 is MSB.
- NUM_FW, 7, forwarding stages per pipe; indices 0..6.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- stall  in  1  hold the current fetch; keep re-resolving latched addresses
- ra_addr_e, rb_addr_e, rc_addr_e  in  7 each  even-slot source addresses
- ra_addr_o, rb_addr_o, rc_addr_o  in  7 each  odd-slot source addresses
- fw_e  in  7x128  even pipe forwarding values; index 0 youngest
- fw_addr_e  in  7x7  even pipe forwarding destinations
- fw_write_e  in  7  even pipe forwarding valid
- fw_o, fw_addr_o, fw_write_o  in  same shapes  odd pipe forwarding
- rt_wb_e, rt_addr_wb_e, reg_write_wb_e  in  128/7/1  even WB write port
- rt_wb_o, rt_addr_wb_o, reg_write_wb_o  in  128/7/1  odd WB write port
- ra_e, rb_e, rc_e  out  128 each  registered even-slot operands
- ra_o, rb_o, rc_o  out  128 each  registered odd-slot operands

Behaviour:
- Reset (async, low):
  - all 128 array entries and all six operand outputs go to 0;
  - latched source addresses go to 0.
- Write:
  - on each rising edge, array[rt_addr_wb_x] <= rt_wb_x when reg_write_wb_x is 1;
  - both ports writing the same address: odd wins (odd slot is later in program order);
  - write with reg_write_wb_x=0 has no effect.
- Address latch:
  - stall=0: at each edge, latch the six input addresses;
  - stall=1: latched addresses hold.
- Resolution address: cycle-N resolution uses the input addresses when stall=0, the latched addresses when stall=1.
- Resolution order (combinational), per operand with resolution address A, first hit wins:
  1. for i = 0..6: odd stage i (fw_write_o[i] && fw_addr_o[i]==A), then even stage i;
  2. odd WB, then even WB (each gated by its write enable);
  3. array[A] (pre-edge content).
- Valid gating: stages 0 and 1 are always driven 0 with write=0 and must not match.
- Latency:
  - operand for addresses presented in cycle N appears on outputs after edge N+1;
  - it reflects forwarding/WB/array state sampled in cycle N.
- Stall: outputs update every edge, even while stalled, so in-flight results that complete during a stall are picked up. The held operation therefore sees the newest value.
- Read-during-write: the same-cycle WB to address A is covered by the WB forward step; no array bypass is needed.
- Address 0 is an ordinary register.
- No X propagation:
  - all mux defaults are array values;
  - unused fw stages never match when write=0.

Decomposition:
- Shared package spu_pkg:
  - constants REG_W=128, ADDR_W=7, NUM_FW=7;
  - typedefs reg_t [0:127], addr_t [0:6];
  - fw_bus_t (7 x reg_t), fw_addr_t (7 x addr_t).
- Sub-module operand_resolve: one operand's priority mux (A, both fw buses, both WB ports, array read value -> operand). Instantiated six times.
- Top module holds the array, address latch and output registers.

Test Plan:
- Reset, then write 0x11..11 to r5 via even WB; next cycle present ra_addr_e=5 -> after one edge ra_e=0x11..11. Assert reset low mid-run -> all outputs 0 immediately; ra_e=0 after release.
- r5 holds 0xAA..AA in the array; even fw stage 4 holds r5=0xBB..BB; odd fw stage 6 holds r5=0xCC..CC -> ra_e=0xBB..BB (younger stage wins).
- Equal stage 2: even and odd both target r9 (0x01.., 0x02..); rb_o=9 -> 0x02..02. Both WB ports write r9 the same cycle -> array later reads 0x02..02.
- Same-cycle WB: odd WB writes r3=0x33..33 while rc_addr_o=3 -> rc_o=0x33..33 after the edge, not the stale array value.
- Stall: present ra_addr_e=7 (array 0x07..), raise stall, change ra_addr_e to 8. Two cycles later even fw stage 2 produces r7=0x77.. -> ra_e goes 0x07.. then 0x77..; never shows r8.
- fw_write=0 with matching address in all stages -> the array value is returned.
